// File: rtl/rr_src_sched_8ch.sv
// Eight single-entry channel buffers with a round-robin grant.
// slot0..7 and sel feed a downstream 8:1 byte mux.
module rr_src_sched_8ch (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [2:0] wr_ch,
  input  logic [7:0] wr_data,
  output logic       wr_err,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [2:0] sel,
  output logic [7:0] slot0,
  output logic [7:0] slot1,
  output logic [7:0] slot2,
  output logic [7:0] slot3,
  output logic [7:0] slot4,
  output logic [7:0] slot5,
  output logic [7:0] slot6,
  output logic [7:0] slot7,
  output logic [7:0] pending
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t     state_q;
  state_t     state_d;
  logic [2:0] sel_q;
  logic [2:0] sel_d;
  logic [2:0] last_q;
  logic [2:0] last_d;
  logic [7:0] pend_q;
  logic [7:0] pend_d;
  logic [7:0] slot_q [8];
  logic       wr_err_q;
  logic       wr_err_d;

  logic       hs;
  logic       wr_ok;
  logic [7:0] sel_oh;
  logic [7:0] wr_oh;
  logic [7:0] mask;
  logic [2:0] base;
  logic [2:0] pick;
  logic       any;

  assign out_valid = (state_q == GRANT);
  assign hs        = out_valid & out_ready;
  assign sel_oh    = 8'b1 << sel_q;
  assign wr_oh     = 8'b1 << wr_ch;

  // A pending channel may only be rewritten as it is being consumed.
  assign wr_ok = wr_en &
                 (~|(pend_q & wr_oh) |
                  (hs & (wr_ch == sel_q)));

  // Same-cycle writes are invisible to the arbiter.
  assign mask = pend_q & ~(hs ? sel_oh : 8'h00);
  assign base = (state_q == GRANT) ? sel_q : last_q;
  assign any  = |mask;

  // Downward scan so the nearest channel after base wins.
  always_comb begin
    pick = base;
    for (int i = 8; i >= 1; i--) begin
      if (mask[base + 3'(i)]) pick = base + 3'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (any) begin
          state_d = GRANT;
          sel_d   = pick;
        end
      end
      GRANT: begin
        if (hs) begin
          last_d = sel_q;
          if (any) sel_d = pick;
          else state_d = IDLE;
        end
      end
      default: ;
    endcase
  end

  assign pend_d = (pend_q & ~(hs ? sel_oh : 8'h00)) |
                  (wr_ok ? wr_oh : 8'h00);
  assign wr_err_d = wr_en & ~wr_ok;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sel_q    <= 3'd0;
      last_q   <= 3'd7;
      pend_q   <= 8'h00;
      wr_err_q <= 1'b0;
      for (int i = 0; i < 8; i++) slot_q[i] <= 8'h00;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      last_q   <= last_d;
      pend_q   <= pend_d;
      wr_err_q <= wr_err_d;
      if (wr_ok) slot_q[wr_ch] <= wr_data;
    end
  end

  assign sel     = sel_q;
  assign pending = pend_q;
  assign wr_err  = wr_err_q;
  assign slot0   = slot_q[0];
  assign slot1   = slot_q[1];
  assign slot2   = slot_q[2];
  assign slot3   = slot_q[3];
  assign slot4   = slot_q[4];
  assign slot5   = slot_q[5];
  assign slot6   = slot_q[6];
  assign slot7   = slot_q[7];

endmodule

// File: tb/tb_rr_src_sched_8ch.sv
// Bench for rr_src_sched_8ch: directed stimulus with a
// queue of expected (channel, byte) handshakes.
module tb_rr_src_sched_8ch;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic [2:0] wr_ch;
  logic [7:0] wr_data;
  logic       wr_err;
  logic       out_ready;
  logic       out_valid;
  logic [2:0] sel;
  logic [7:0] slot0, slot1, slot2, slot3;
  logic [7:0] slot4, slot5, slot6, slot7;
  logic [7:0] pending;
  logic [7:0] mux_out;

  int n_chk = 0;
  int n_fail = 0;
  logic [10:0] exp_q [$];

  always #5 clk = ~clk;

  rr_src_sched_8ch dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_ch(wr_ch), .wr_data(wr_data),
    .wr_err(wr_err), .out_ready(out_ready),
    .out_valid(out_valid), .sel(sel),
    .slot0(slot0), .slot1(slot1), .slot2(slot2),
    .slot3(slot3), .slot4(slot4), .slot5(slot5),
    .slot6(slot6), .slot7(slot7), .pending(pending)
  );

  always_comb begin
    case (sel)
      3'd0: mux_out = slot0;
      3'd1: mux_out = slot1;
      3'd2: mux_out = slot2;
      3'd3: mux_out = slot3;
      3'd4: mux_out = slot4;
      3'd5: mux_out = slot5;
      3'd6: mux_out = slot6;
      default: mux_out = slot7;
    endcase
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] ch, input logic [7:0] d);
    wr_en = 1'b1;
    wr_ch = ch;
    wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  function automatic logic [63:0] all_slots();
    return {slot7, slot6, slot5, slot4,
            slot3, slot2, slot1, slot0};
  endfunction

  // Inputs change only #1 after posedge, so a handshake seen
  // here completes at the next rising edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("hs_unexpected", {61'd0, sel}, 64'hFFFF);
      end else begin
        logic [10:0] e;
        e = exp_q.pop_front();
        chk("hs_ch", {61'd0, sel}, {61'd0, e[10:8]});
        chk("hs_data", {56'd0, mux_out}, {56'd0, e[7:0]});
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    wr_en = 1'b0;
    wr_ch = 3'd0;
    wr_data = 8'h00;
    out_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;

    // reset then idle
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("rst_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_pend", {56'd0, pending}, 64'd0);
      chk("rst_sel", {61'd0, sel}, 64'd0);
      chk("rst_slots", all_slots(), 64'd0);
      chk("rst_err", {63'd0, wr_err}, 64'd0);
    end

    // single write latency
    out_ready = 1'b1;
    exp_q.push_back({3'd5, 8'hA7});
    wr(3'd5, 8'hA7);
    chk("lat_pend", {56'd0, pending}, 64'h20);
    chk("lat_valid0", {63'd0, out_valid}, 64'd0);
    tick();
    chk("lat_valid1", {63'd0, out_valid}, 64'd1);
    chk("lat_sel", {61'd0, sel}, 64'd5);
    chk("lat_slot5", {56'd0, slot5}, 64'hA7);
    tick();
    chk("lat_pend_clr", {56'd0, pending}, 64'd0);
    chk("lat_idle", {63'd0, out_valid}, 64'd0);

    // round-robin order
    out_ready = 1'b0;
    exp_q.push_back({3'd1, 8'h11});
    exp_q.push_back({3'd3, 8'h33});
    exp_q.push_back({3'd6, 8'h66});
    wr(3'd1, 8'h11);
    wr(3'd3, 8'h33);
    wr(3'd6, 8'h66);
    chk("rr_pend", {56'd0, pending}, 64'h4A);
    chk("rr_sel1", {61'd0, sel}, 64'd1);
    out_ready = 1'b1;
    tick();
    chk("rr_sel3", {61'd0, sel}, 64'd3);
    chk("rr_v3", {63'd0, out_valid}, 64'd1);
    tick();
    chk("rr_sel6", {61'd0, sel}, 64'd6);
    chk("rr_v6", {63'd0, out_valid}, 64'd1);
    tick();
    chk("rr_idle", {63'd0, out_valid}, 64'd0);
    out_ready = 1'b0;
    exp_q.push_back({3'd1, 8'h12});
    exp_q.push_back({3'd6, 8'h67});
    wr(3'd1, 8'h12);
    wr(3'd6, 8'h67);
    chk("rr2_sel1", {61'd0, sel}, 64'd1);
    out_ready = 1'b1;
    tick();
    chk("rr2_sel6", {61'd0, sel}, 64'd6);
    tick();
    chk("rr2_idle", {63'd0, out_valid}, 64'd0);

    // backpressure and reject
    out_ready = 1'b0;
    exp_q.push_back({3'd2, 8'h42});
    wr(3'd2, 8'h42);
    tick();
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        wr(3'd2, 8'hFF);
        chk("bp_err1", {63'd0, wr_err}, 64'd1);
      end else begin
        tick();
        chk("bp_err0", {63'd0, wr_err}, 64'd0);
      end
      chk("bp_sel", {61'd0, sel}, 64'd2);
      chk("bp_valid", {63'd0, out_valid}, 64'd1);
      chk("bp_slot2", {56'd0, slot2}, 64'h42);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_idle", {63'd0, out_valid}, 64'd0);
    chk("bp_pend", {56'd0, pending}, 64'd0);

    // same-cycle consume and refill
    out_ready = 1'b0;
    exp_q.push_back({3'd4, 8'h44});
    exp_q.push_back({3'd5, 8'h55});
    exp_q.push_back({3'd4, 8'h9C});
    wr(3'd4, 8'h44);
    wr(3'd5, 8'h55);
    tick();
    chk("cr_sel4", {61'd0, sel}, 64'd4);
    out_ready = 1'b1;
    wr(3'd4, 8'h9C);
    chk("cr_err", {63'd0, wr_err}, 64'd0);
    chk("cr_pend", {56'd0, pending}, 64'h30);
    chk("cr_slot4", {56'd0, slot4}, 64'h9C);
    chk("cr_sel5", {61'd0, sel}, 64'd5);
    tick();
    chk("cr_regrant", {61'd0, sel}, 64'd4);
    chk("cr_v", {63'd0, out_valid}, 64'd1);
    tick();
    chk("cr_idle", {63'd0, out_valid}, 64'd0);

    // reset mid-operation
    out_ready = 1'b0;
    wr(3'd3, 8'h31);
    for (int c = 0; c < 8; c++) begin
      if (c != 3) wr(3'(c), 8'(c * 16 + 1));
    end
    chk("mr_pend", {56'd0, pending}, 64'hFF);
    chk("mr_sel3", {61'd0, sel}, 64'd3);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mr_valid", {63'd0, out_valid}, 64'd0);
    chk("mr_pend0", {56'd0, pending}, 64'd0);
    chk("mr_slots", all_slots(), 64'd0);
    chk("mr_sel0", {61'd0, sel}, 64'd0);
    for (int c = 0; c < 8; c++) begin
      exp_q.push_back({3'(c), 8'(c * 16 + 2)});
      wr(3'(c), 8'(c * 16 + 2));
    end
    chk("mr_first", {61'd0, sel}, 64'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    tick();
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
    chk("drain_idle", {63'd0, out_valid}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
